// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access -- memory pipeline stage (downstream of execute)
//
// Accepts one instruction per cycle while idle. ALU ops pass straight through
// with one cycle of latency. Loads and stores issue a single transaction on a
// req/gnt/rvalid data-memory bus. Load data is lane-aligned and sign- or
// zero-extended before writeback. Upstream is stalled while a transaction is
// in flight.
//
// Optional build macro:
//   MEM_MISALIGN_TRAP_EN  misaligned ld/st is not sent to the bus. It completes
//                         like an ALU op and raises misalign_o. Without this
//                         macro the address is rounded down to the access size
//                         and the access goes ahead normally.
//
// Parameters:
//   ADDR_W   width of dmem_addr_o (low ADDR_W bits of alu_result_i)
//   TIMEOUT  WAIT cycles without rvalid before the access is aborted (0 = never)
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   valid_i/opcode_i/alu_result_i/store_data_i/rd_i   instruction from execute
//   stall_o                     upstream must hold its inputs
//   dmem_req_o/we_o/addr_o/be_o/wdata_o               bus request side
//   dmem_gnt_i/rvalid_i/rdata_i                       bus grant / response
//   valid_o/rd_o/wb_en_o/wb_data_o                    writeback result
//   err_o, misalign_o           status pulses that accompany valid_o
// -----------------------------------------------------------------------------
module mem_access #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [4:0]        opcode_i,
    input  logic [31:0]       alu_result_i,
    input  logic [31:0]       store_data_i,
    input  logic [4:0]        rd_i,
    output logic              stall_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [31:0]       dmem_rdata_i,
    output logic              valid_o,
    output logic [4:0]        rd_o,
    output logic              wb_en_o,
    output logic [31:0]       wb_data_o,
    output logic              err_o,
    output logic              misalign_o
);

    localparam logic [4:0] OP_LB  = 5'b01000;
    localparam logic [4:0] OP_LH  = 5'b01001;
    localparam logic [4:0] OP_LW  = 5'b01010;
    localparam logic [4:0] OP_LBU = 5'b01100;
    localparam logic [4:0] OP_LHU = 5'b01101;
    localparam logic [4:0] OP_SB  = 5'b10000;
    localparam logic [4:0] OP_SH  = 5'b10001;
    localparam logic [4:0] OP_SW  = 5'b10010;

    // Counter holds 0..TIMEOUT-1; the abort fires on the cycle it sits at the top.
    localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam bit              TO_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic [4:0]        rdst_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              valid_q;
    logic [4:0]        rd_q;
    logic              wb_en_q;
    logic [31:0]       wb_data_q;
    logic              err_q;
    logic              mis_q;

    // Decode of the incoming instruction (size: 0 byte, 1 half, 2 word)
    logic              is_mem_d;
    logic              is_st_d;
    logic [1:0]        size_d;
    logic              uns_d;
    logic [1:0]        a_raw;
    logic [1:0]        a_al_d;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic [ADDR_W-1:0] addr_d;
    logic              trap_d;

    always_comb begin
        is_mem_d = 1'b0;
        is_st_d  = 1'b0;
        size_d   = 2'd2;
        uns_d    = 1'b0;
        unique case (opcode_i)
            OP_LB:   begin is_mem_d = 1'b1; size_d = 2'd0; end
            OP_LH:   begin is_mem_d = 1'b1; size_d = 2'd1; end
            OP_LW:   begin is_mem_d = 1'b1; size_d = 2'd2; end
            OP_LBU:  begin is_mem_d = 1'b1; size_d = 2'd0; uns_d = 1'b1; end
            OP_LHU:  begin is_mem_d = 1'b1; size_d = 2'd1; uns_d = 1'b1; end
            OP_SB:   begin is_mem_d = 1'b1; is_st_d = 1'b1; size_d = 2'd0; end
            OP_SH:   begin is_mem_d = 1'b1; is_st_d = 1'b1; size_d = 2'd1; end
            OP_SW:   begin is_mem_d = 1'b1; is_st_d = 1'b1; size_d = 2'd2; end
            default: ;
        endcase

        a_raw = alu_result_i[1:0];
        // Round down to the access size; a no-op for aligned accesses.
        unique case (size_d)
            2'd0:    a_al_d = a_raw;
            2'd1:    a_al_d = {a_raw[1], 1'b0};
            default: a_al_d = 2'b00;
        endcase

        unique case (size_d)
            2'd0:    be_d = 4'b0001 << a_al_d;
            2'd1:    be_d = a_al_d[1] ? 4'b1100 : 4'b0011;
            default: be_d = 4'b1111;
        endcase

        // Store data is replicated across lanes; byte enables pick the lane.
        wdata_d = '0;
        if (is_st_d) begin
            unique case (size_d)
                2'd0:    wdata_d = {4{store_data_i[7:0]}};
                2'd1:    wdata_d = {2{store_data_i[15:0]}};
                default: wdata_d = store_data_i;
            endcase
        end

        addr_d = {alu_result_i[ADDR_W-1:2], a_al_d};
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap_d = is_mem_d &&
                    (((size_d == 2'd1) && a_raw[0]) || ((size_d == 2'd2) && (a_raw != 2'b00)));
`else
    assign trap_d = 1'b0;
`endif

    // Load data extraction from the response, using the latched lane/size
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        unique case (addr_q[1:0])
            2'd0:    ld_byte = dmem_rdata_i[7:0];
            2'd1:    ld_byte = dmem_rdata_i[15:8];
            2'd2:    ld_byte = dmem_rdata_i[23:16];
            default: ld_byte = dmem_rdata_i[31:24];
        endcase
        ld_half = addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        unique case (size_q)
            2'd0:    ld_data = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'd1:    ld_data = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            rdst_q    <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            rd_q      <= '0;
            wb_en_q   <= 1'b0;
            wb_data_q <= '0;
            err_q     <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (valid_i) begin
                        if (is_mem_d && !trap_d) begin
                            addr_q  <= addr_d;
                            be_q    <= be_d;
                            wdata_q <= wdata_d;
                            we_q    <= is_st_d;
                            rdst_q  <= rd_i;
                            size_q  <= size_d;
                            uns_q   <= uns_d;
                            state_q <= S_REQ;
                        end else begin
                            // ALU op, or a trapped misaligned access
                            valid_q   <= 1'b1;
                            rd_q      <= rd_i;
                            mis_q     <= trap_d;
                            wb_en_q   <= !trap_d && (rd_i != 5'd0);
                            wb_data_q <= trap_d ? 32'h0 : alu_result_i;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_gnt_i) begin
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid_i) begin
                        valid_q   <= 1'b1;
                        rd_q      <= rdst_q;
                        wb_en_q   <= !we_q && (rdst_q != 5'd0);
                        wb_data_q <= we_q ? 32'h0 : ld_data;
                        state_q   <= S_IDLE;
                    end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                        valid_q <= 1'b1;
                        err_q   <= 1'b1;
                        rd_q    <= rdst_q;
                        wb_en_q <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stall_o      = (state_q != S_IDLE);
    assign dmem_req_o   = (state_q == S_REQ);
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;
    assign valid_o      = valid_q;
    assign rd_o         = rd_q;
    assign wb_en_o      = wb_en_q;
    assign wb_data_o    = wb_data_q;
    assign err_o        = err_q;
    assign misalign_o   = mis_q;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    localparam int TO = 4;
    localparam logic [4:0] LB = 5'b01000, LH = 5'b01001, LW = 5'b01010,
                           LBU = 5'b01100, LHU = 5'b01101,
                           SB = 5'b10000, SH = 5'b10001, SW = 5'b10010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic [4:0]  opcode_i;
    logic [31:0] alu_result_i;
    logic [31:0] store_data_i;
    logic [4:0]  rd_i;
    logic        stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        valid_o;
    logic [4:0]  rd_o;
    logic        wb_en_o;
    logic [31:0] wb_data_o;
    logic        err_o;
    logic        misalign_o;

    always #5 clk = ~clk;

    mem_access #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .opcode_i(opcode_i),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i), .rd_i(rd_i),
        .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .valid_o(valid_o), .rd_o(rd_o), .wb_en_o(wb_en_o), .wb_data_o(wb_data_o),
        .err_o(err_o), .misalign_o(misalign_o)
    );

    int errors = 0;
    int checks = 0;

    // Scoreboard of expected writeback results, in issue order
    typedef struct {
        logic [4:0]  rd;
        logic        wb_en;
        logic [31:0] data;
        logic        chk_data;
        logic        err;
        logic        mis;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid_o === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: valid_o=1 rd=%0d data=%h with nothing pending", rd_o, wb_data_o);
            end else begin
                mon_e = sb.pop_front();
                if ({rd_o, wb_en_o, err_o, misalign_o} !== {mon_e.rd, mon_e.wb_en, mon_e.err, mon_e.mis} ||
                    (mon_e.chk_data && wb_data_o !== mon_e.data)) begin
                    errors++;
                    $display("FAIL sb_result: got rd=%0d en=%b err=%b mis=%b data=%h, want rd=%0d en=%b err=%b mis=%b data=%h",
                             rd_o, wb_en_o, err_o, misalign_o, wb_data_o,
                             mon_e.rd, mon_e.wb_en, mon_e.err, mon_e.mis, mon_e.data);
                end
            end
        end
    end

    function automatic logic [31:0] ld_model(input logic [4:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [31:0] s8, s16;
        s8  = rdata >> (8 * addr[1:0]);
        s16 = rdata >> (addr[1] ? 16 : 0);
        case (op)
            LB:      return {{24{s8[7]}}, s8[7:0]};
            LBU:     return {24'h0, s8[7:0]};
            LH:      return {{16{s16[15]}}, s16[15:0]};
            LHU:     return {16'h0, s16[15:0]};
            default: return rdata;
        endcase
    endfunction

    // Drives a full ld/st on a fixed schedule; entered and left at posedge+1.
    // Returns at the start of the cycle in which valid_o is expected.
    task automatic bus_txn(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] sd,
                           input logic [4:0] rd, input int gnt_dly, input logic [31:0] rdata);
        valid_i = 1'b1; opcode_i = op; alu_result_i = addr; store_data_i = sd; rd_i = rd;
        @(posedge clk); #1 valid_i = 1'b0;
        for (int i = 0; i <= gnt_dly; i++) begin
            dmem_gnt_i = (i == gnt_dly);
            @(posedge clk); #1;
        end
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
        @(posedge clk); #1 dmem_rvalid_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({stall_o, dmem_req_o, dmem_we_o, valid_o, wb_en_o, err_o, misalign_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b, want 0000000",
                     {stall_o, dmem_req_o, dmem_we_o, valid_o, wb_en_o, err_o, misalign_o});
        end
        checks++;
        if ({dmem_addr_o, dmem_be_o, dmem_wdata_o, wb_data_o, rd_o} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h be=%b wdata=%h wb=%h rd=%0d, want all 0",
                     dmem_addr_o, dmem_be_o, dmem_wdata_o, wb_data_o, rd_o);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_alu();
        logic [4:0]  ops [3] = '{5'b00000, 5'b00011, 5'b01011};
        logic [31:0] alus[3] = '{32'h1234, 32'hDEAD_BEEF, 32'hCAFE_0001};
        logic [4:0]  rds [3] = '{5'd5, 5'd0, 5'd3};
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{rds[i], rds[i] != 5'd0, alus[i], 1'b1, 1'b0, 1'b0});
            valid_i = 1'b1; opcode_i = ops[i]; alu_result_i = alus[i]; rd_i = rds[i];
            @(negedge clk);
            checks++;
            if (stall_o !== 1'b0 || valid_o !== 1'b0) begin
                errors++;
                $display("FAIL alu_accept[%0d]: stall=%b valid=%b, want 0 0", i, stall_o, valid_o);
            end
            @(posedge clk); #1 valid_i = 1'b0;
            @(negedge clk);
            checks++;
            if (valid_o !== 1'b1 || stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin
                errors++;
                $display("FAIL alu_latency[%0d]: valid=%b stall=%b req=%b, want 1 0 0",
                         i, valid_o, stall_o, dmem_req_o);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_sign();
        logic [4:0]  ops[2] = '{LB, LBU};
        logic [31:0] exp[2] = '{32'hFFFF_FF80, 32'h0000_0080};
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{5'd7, 1'b1, exp[i], 1'b1, 1'b0, 1'b0});
            bus_txn(ops[i], 32'h103, 32'h0, 5'd7, 0, 32'h80FF_FFFF);
            @(negedge clk);
            checks++;
            if (valid_o !== 1'b1 || wb_data_o !== exp[i]) begin
                errors++;
                $display("FAIL load_ext[%0d]: valid=%b data=%h, want 1 %h", i, valid_o, wb_data_o, exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_random();
        logic [4:0]  ops[5] = '{LB, LH, LW, LBU, LHU};
        logic [4:0]  op, rd;
        logic [31:0] addr, rdata;
        int          gd;
        for (int i = 0; i < 12; i++) begin
            op    = ops[$urandom_range(0, 4)];
            addr  = $urandom & 32'h0000_FFFF;
            rdata = $urandom;
            rd    = 5'($urandom_range(0, 31));
            gd    = $urandom_range(0, 2);
`ifdef MEM_MISALIGN_TRAP_EN
            if (op == LW) addr[1:0] = 2'b00;
            if (op == LH || op == LHU) addr[0] = 1'b0;
`endif
            sb.push_back('{rd, rd != 5'd0, ld_model(op, addr, rdata), 1'b1, 1'b0, 1'b0});
            bus_txn(op, addr, 32'h0, rd, gd, rdata);
            @(negedge clk);
            checks++;
            if (valid_o !== 1'b1) begin
                errors++;
                $display("FAIL load_rand_valid[%0d]: valid=%b, want 1", i, valid_o);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store();
        logic [4:0]  ops [3] = '{SH, SB, SW};
        logic [31:0] adrs[3] = '{32'h102, 32'h101, 32'h300};
        logic [31:0] sds [3] = '{32'h1234_ABCD, 32'h0000_005A, 32'h89AB_CDEF};
        logic [3:0]  bes [3] = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] wds [3] = '{32'hABCD_ABCD, 32'h5A5A_5A5A, 32'h89AB_CDEF};
        int          gds [3] = '{3, 0, 1};
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{5'd9, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0});
            valid_i = 1'b1; opcode_i = ops[i]; alu_result_i = adrs[i]; store_data_i = sds[i]; rd_i = 5'd9;
            @(posedge clk); #1 valid_i = 1'b0;
            for (int c = 0; c <= gds[i]; c++) begin
                dmem_gnt_i = (c == gds[i]);
                @(negedge clk);
                checks++;
                if ({dmem_req_o, stall_o, dmem_we_o} !== 3'b111 || dmem_addr_o !== adrs[i] ||
                    dmem_be_o !== bes[i] || dmem_wdata_o !== wds[i]) begin
                    errors++;
                    $display("FAIL store_bus[%0d.%0d]: req/stall/we=%b addr=%h be=%b wdata=%h, want 111 %h %b %h",
                             i, c, {dmem_req_o, stall_o, dmem_we_o}, dmem_addr_o, dmem_be_o, dmem_wdata_o,
                             adrs[i], bes[i], wds[i]);
                end
                @(posedge clk); #1;
            end
            dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1;
            @(posedge clk); #1 dmem_rvalid_i = 1'b0;
            @(negedge clk);
            checks++;
            if (valid_o !== 1'b1 || stall_o !== 1'b0) begin
                errors++;
                $display("FAIL store_done[%0d]: valid=%b stall=%b, want 1 0", i, valid_o, stall_o);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        sb.push_back('{5'd4, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0});
        valid_i = 1'b1; opcode_i = LW; alu_result_i = 32'h200; rd_i = 5'd4;
        @(posedge clk); #1 valid_i = 1'b0; dmem_gnt_i = 1'b1;
        @(posedge clk); #1 dmem_gnt_i = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (valid_o === 1'b1) begin n = c; break; end
        end
        checks++;
        if (n != TO + 1 || err_o !== 1'b1 || wb_en_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout: valid at wait cycle %0d err=%b en=%b, want %0d 1 0", n, err_o, wb_en_o, TO + 1);
        end
        @(posedge clk); #1 dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5555_5555;
        @(posedge clk); #1 dmem_rvalid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_late_rvalid: valid=%b stall=%b, want 0 0", valid_o, stall_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
        sb.push_back('{5'd6, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1});
        valid_i = 1'b1; opcode_i = LW; alu_result_i = 32'h201; rd_i = 5'd6;
        @(negedge clk);
        @(posedge clk); #1 valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || misalign_o !== 1'b1 || dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL misalign_trap: valid=%b mis=%b req=%b stall=%b, want 1 1 0 0",
                     valid_o, misalign_o, dmem_req_o, stall_o);
        end
        @(posedge clk); #1;
`else
        sb.push_back('{5'd6, 1'b1, 32'h1122_3344, 1'b1, 1'b0, 1'b0});
        valid_i = 1'b1; opcode_i = LW; alu_result_i = 32'h201; rd_i = 5'd6;
        @(posedge clk); #1 valid_i = 1'b0; dmem_gnt_i = 1'b1;
        @(negedge clk);
        checks++;
        if (dmem_req_o !== 1'b1 || dmem_addr_o !== 32'h200 || dmem_be_o !== 4'b1111) begin
            errors++;
            $display("FAIL misalign_align: req=%b addr=%h be=%b, want 1 00000200 1111",
                     dmem_req_o, dmem_addr_o, dmem_be_o);
        end
        @(posedge clk); #1 dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1122_3344;
        @(posedge clk); #1 dmem_rvalid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL misalign_noflag: valid=%b mis=%b, want 1 0", valid_o, misalign_o);
        end
        @(posedge clk); #1;
`endif
    endtask

    task automatic test_reset_mid();
        valid_i = 1'b1; opcode_i = LW; alu_result_i = 32'h400; rd_i = 5'd8;
        @(posedge clk); #1 valid_i = 1'b0; dmem_gnt_i = 1'b1;
        @(posedge clk); #1 dmem_gnt_i = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (dmem_req_o !== 1'b0 || stall_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: req=%b stall=%b valid=%b, want 0 0 0", dmem_req_o, stall_o, valid_o);
        end
        @(posedge clk); #1 rst_n = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hAAAA_AAAA;
        @(posedge clk); #1 dmem_rvalid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop: valid=%b, want 0", valid_o);
        end
        @(posedge clk); #1;
        sb.push_back('{5'd2, 1'b1, 32'h0000_0077, 1'b1, 1'b0, 1'b0});
        valid_i = 1'b1; opcode_i = 5'b00001; alu_result_i = 32'h77; rd_i = 5'd2;
        @(posedge clk); #1 valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_alu_after: valid=%b, want 1", valid_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        sb.push_back('{5'd10, 1'b1, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0});
        sb.push_back('{5'd11, 1'b1, 32'h0000_0ABC, 1'b1, 1'b0, 1'b0});
        bus_txn(LH, 32'h102, 32'h0, 5'd10, 0, 32'h8001_7FFF);
        valid_i = 1'b1; opcode_i = 5'b00000; alu_result_i = 32'hABC; rd_i = 5'd11;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_load: valid=%b stall=%b, want 1 0", valid_o, stall_o);
        end
        @(posedge clk); #1 valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || wb_data_o !== 32'h0000_0ABC) begin
            errors++;
            $display("FAIL b2b_alu: valid=%b data=%h, want 1 00000abc", valid_o, wb_data_o);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; opcode_i = '0; alu_result_i = '0; store_data_i = '0; rd_i = '0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        test_reset();
        test_alu();
        test_load_sign();
        test_load_random();
        test_store();
        test_timeout();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d results never produced, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
